mux_arb_nto1: RTL and testbench

//  Parametrised N-input, W-bit registered multiplexer with valid/ready handshakes.

---
 rtl/mux_arb_nto1.sv | 128 ++++++++++++
 tb/tb_mux_arb_nto1.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_nto1.sv
// N-input registered stream mux: explicit-select or round-robin grant feeding one
// output register with valid/ready on both sides and full-throughput reload.

module mux_arb_nto1_lane #(
  parameter int W   = 64,
  parameter int SW  = 2,
  parameter int IDX = 0
) (
  input  logic          arm,
  input  logic          grant_valid,
  input  logic [SW-1:0] g,
  input  logic [W-1:0]  din,
  output logic          rdy,
  output logic [W-1:0]  dout
);
  logic hit;

  assign hit  = grant_valid & (g == SW'(IDX));
  assign rdy  = arm & hit;
  // Masked data lets the top OR-reduce lanes instead of indexing by g.
  assign dout = hit ? din : '0;
endmodule

module mux_arb_nto1 #(
  parameter int N  = 4,
  parameter int W  = 64,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  input  logic           out_ready
);
  localparam int NP = 1 << SW;

  logic [N-1:0][W-1:0] din_a;
  logic [N-1:0][W-1:0] dmask;
  logic [NP-1:0]       vpad;
  logic [SW-1:0]       rr_ptr;
  logic [SW-1:0]       g_rr, g;
  logic                rr_hit, grant_valid, sel_ok;
  logic                load_en, arm, xfer;
  logic [W-1:0]        mux_d;

  assign din_a   = in_data;
  assign vpad    = NP'(in_valid);
  assign load_en = !out_valid | out_ready;
  // Reset gates readiness so no producer sees a handshake while held in reset.
  assign arm     = reset_n & load_en;
  assign xfer    = arm & grant_valid;

  generate
    if (NP == N) begin : g_sel_full
      assign sel_ok = 1'b1;
    end else begin : g_sel_chk
      assign sel_ok = ({1'b0, sel} < (SW+1)'(N));
    end
  endgenerate

  // Walk from rr_ptr downward in priority so the nearest valid channel wins last.
  always_comb begin
    int idx;
    g_rr   = '0;
    rr_hit = 1'b0;
    idx    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (in_valid[idx]) begin
        rr_hit = 1'b1;
        g_rr   = SW'(idx);
      end
    end
  end

  always_comb begin
    g           = sel;
    grant_valid = sel_ok & vpad[sel];
    if (mode) begin
      g           = g_rr;
      grant_valid = rr_hit;
    end
  end

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_lane
      mux_arb_nto1_lane #(.W(W), .SW(SW), .IDX(i)) u_lane (
        .arm         (arm),
        .grant_valid (grant_valid),
        .g           (g),
        .din         (din_a[i]),
        .rdy         (in_ready[i]),
        .dout        (dmask[i])
      );
    end
  endgenerate

  always_comb begin
    mux_d = '0;
    for (int k = 0; k < N; k++) mux_d = mux_d | dmask[k];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= mux_d;
        out_chan  <= g;
        if (mode) rr_ptr <= (g == SW'(N - 1)) ? '0 : g + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux_arb_nto1.sv
// Directed checks on a 4x8 instance plus a scoreboarded random run on a 3x16 instance.

module tb_mux_arb_nto1;
  logic        clk, reset_n;
  logic        mode, out_ready, out_valid;
  logic [1:0]  sel, out_chan;
  logic [3:0]  in_valid, in_ready;
  logic [31:0] in_data;
  logic [7:0]  out_data;

  logic        mode2, out_ready2, out_valid2;
  logic [1:0]  sel2, out_chan2;
  logic [2:0]  in_valid2, in_ready2;
  logic [47:0] in_data2;
  logic [15:0] out_data2;

  int errors = 0;
  int checks = 0;

  mux_arb_nto1 #(.N(4), .W(8)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
    .out_ready(out_ready)
  );

  mux_arb_nto1 #(.N(3), .W(16)) dut2 (
    .clk(clk), .reset_n(reset_n), .mode(mode2), .sel(sel2),
    .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_chan(out_chan2),
    .out_ready(out_ready2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mode = 0; sel = 0; in_valid = 0; out_ready = 0;
    mode2 = 0; sel2 = 0; in_valid2 = 0; in_data2 = 0; out_ready2 = 0;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mode = 1; sel = 0; in_valid = 4'b1111; out_ready = 1;
    mode2 = 0; sel2 = 0; in_valid2 = 0; in_data2 = 0; out_ready2 = 0;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL rst_in_ready got=%b exp=0000", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
    checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL rst_out_chan got=%0d exp=0", out_chan); end
    step();
    reset_n = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rst_first_grant got=%b exp=0001", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'h11) begin
      errors++; $display("FAIL rst_first_beat got=%b/%0d/%h exp=1/0/11", out_valid, out_chan, out_data); end
    out_ready = 0;
    step();
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++; $display("FAIL rst_mid_stall got=%b/%h exp=0/00", out_valid, out_data); end
    step();
    reset_n = 1'b1;
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL rst_rr_ptr got=%b exp=0001", in_ready); end
  endtask

  task automatic test_explicit();
    do_reset();
    mode = 0; sel = 2; in_valid = 4'b1111; out_ready = 1;
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL sel2_ready got=%b exp=0100", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h33 || out_chan !== 2'd2) begin
      errors++; $display("FAIL sel2_beat got=%b/%h/%0d exp=1/33/2", out_valid, out_data, out_chan); end
    sel = 3; in_valid = 4'b0111;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL sel3_invalid_ready got=%b exp=0000", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h33 || out_chan !== 2'd2) begin
      errors++; $display("FAIL sel3_drain got=%b/%h/%0d exp=0/33/2", out_valid, out_data, out_chan); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_a [8];
    logic [1:0] exp_b [4];
    exp_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    exp_b = '{2'd1, 2'd3, 2'd1, 2'd3};
    do_reset();
    mode = 1; in_valid = 4'b1111; out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (in_ready !== (4'b0001 << exp_a[k])) begin
        errors++; $display("FAIL rr_all_ready[%0d] got=%b exp_chan=%0d", k, in_ready, exp_a[k]); end
      step();
      checks++; if (out_valid !== 1'b1 || out_chan !== exp_a[k]) begin
        errors++; $display("FAIL rr_all_chan[%0d] got=%b/%0d exp=1/%0d", k, out_valid, out_chan, exp_a[k]); end
    end
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_chan !== exp_b[k]) begin
        errors++; $display("FAIL rr_1010_chan[%0d] got=%b/%0d exp=1/%0d", k, out_valid, out_chan, exp_b[k]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 0; sel = 1; in_valid = 4'b0010; out_ready = 1;
    in_data[15:8] = 8'hAA;
    step();
    out_ready = 0;
    in_data[15:8] = 8'hBB;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'hAA || out_chan !== 2'd1) begin
        errors++; $display("FAIL stall[%0d] got rdy=%b v=%b d=%h c=%0d exp 0000/1/aa/1", k, in_ready, out_valid, out_data, out_chan); end
      step();
    end
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL release_ready got=%b exp=0010", in_ready); end
    step();
    in_valid = 4'b0000;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hBB) begin
      errors++; $display("FAIL release_reload got=%b/%h exp=1/bb", out_valid, out_data); end
    step();
    checks++; if (out_valid !== 1'b0 || out_data !== 8'hBB) begin
      errors++; $display("FAIL release_drain got=%b/%h exp=0/bb", out_valid, out_data); end
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 1; in_valid = 4'b1110; out_ready = 1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL ms_rr_first got=%b exp=0010", in_ready); end
    step();
    mode = 0; sel = 0; in_valid = 4'b1111;
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL ms_sel0_ready got=%b exp=0001", in_ready); end
    step();
    checks++; if (out_chan !== 2'd0 || out_data !== 8'h11) begin
      errors++; $display("FAIL ms_sel0_beat got=%0d/%h exp=0/11", out_chan, out_data); end
    mode = 1;
    #1;
    checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL ms_rr_resume got=%b exp=0100", in_ready); end
    step();
    checks++; if (out_chan !== 2'd2 || out_data !== 8'h33) begin
      errors++; $display("FAIL ms_rr_beat got=%0d/%h exp=2/33", out_chan, out_data); end
  endtask

  task automatic test_scoreboard_random();
    logic [17:0] sbq [$];
    logic [17:0] expv;
    logic [2:0]  hs;
    bit          drained;
    do_reset();
    hs = '0;
    drained = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      for (int i = 0; i < 3; i++) if (hs[i]) in_valid2[i] = 1'b0;
      if (c < 300) begin
        for (int i = 0; i < 3; i++)
          if (!in_valid2[i] && $urandom_range(0, 1) == 1) begin
            in_valid2[i] = 1'b1;
            in_data2[i*16 +: 16] = 16'($urandom);
          end
        mode2 = 1'($urandom_range(0, 1));
        sel2 = 2'($urandom_range(0, 3));
        out_ready2 = ($urandom_range(0, 9) < 7);
      end else begin
        if (in_valid2 == 3'b000 && !out_valid2 && sbq.size() == 0) begin
          drained = 1;
          break;
        end
        mode2 = 1; out_ready2 = 1;
      end
      #1;
      checks++;
      if (!$onehot0(in_ready2) || (in_ready2 & ~in_valid2) != 3'b000 ||
          (mode2 == 1'b0 && in_ready2 != 3'b000 && in_ready2 != (3'b001 << sel2))) begin
        errors++; $display("FAIL rand_ready_legal[%0d] rdy=%b vld=%b mode=%b sel=%0d", c, in_ready2, in_valid2, mode2, sel2);
      end
      hs = in_valid2 & in_ready2;
      for (int i = 0; i < 3; i++) if (hs[i]) sbq.push_back({2'(i), in_data2[i*16 +: 16]});
      if (out_valid2 && out_ready2) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++; $display("FAIL rand_unexpected_beat[%0d] got=%0d/%h", c, out_chan2, out_data2);
        end else begin
          expv = sbq.pop_front();
          if ({out_chan2, out_data2} !== expv) begin
            errors++; $display("FAIL rand_beat[%0d] got=%0d/%h exp=%0d/%h", c, out_chan2, out_data2, expv[17:16], expv[15:0]);
          end
        end
      end
    end
    checks++;
    if (!drained) begin
      errors++; $display("FAIL rand_drain_timeout pending_in=%b queued=%0d", in_valid2, sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_explicit();
    test_round_robin();
    test_backpressure();
    test_mode_switch();
    test_scoreboard_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
